// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: SPI mode-0 master for an MCP3008-class 10-bit ADC.
// Runs one single-ended conversion every SAMPLE_PERIOD clocks and publishes
// the 10-bit result with a one-clock valid pulse.
// Optional throttle mapping is enabled with `define ADC_SPI_SAMPLER_ACCEL_MAP_EN;
// without it o_accel is tied to zero.
module adc_spi_sampler #(
   parameter int CLK_DIV       = 675,
   parameter int SAMPLE_PERIOD = 86400,
   parameter int CS_HIGH_CYC   = 1350,
   parameter int ACCEL_LO      = 280,
   parameter int ACCEL_HI      = 780
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_enable,
   input  logic [2:0] i_channel,
   output logic       o_sclk,
   output logic       o_cs_n,
   output logic       o_mosi,
   input  logic       i_miso,
   output logic [9:0] o_sample,
   output logic       o_sample_valid,
   output logic       o_busy,
   output logic [9:0] o_accel
);

   // Counter widths; every counter is at least one bit wide
   localparam int PCW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int DCW = $clog2(CLK_DIV + 1);
   localparam int GCW = $clog2(CS_HIGH_CYC + 1);

   localparam logic [PCW-1:0] PERIOD_LAST = PCW'(SAMPLE_PERIOD - 1);
   localparam logic [DCW-1:0] DIV_LAST    = DCW'(CLK_DIV - 1);
   localparam logic [GCW-1:0] GAP_LAST    = GCW'(CS_HIGH_CYC - 1);

   // Bit indices are zero-based: index 0 is the start bit, 7..16 carry B9..B0
   localparam logic [4:0] BIT_LAST   = 5'd16;
   localparam logic [4:0] DATA_FIRST = 5'd7;

   // Frame state machine encoding
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_XFER = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [1:0] S_GAP  = 2'd3;

   // Command bit driven on DIN for a given zero-based bit index
   function automatic logic cmd_bit(input logic [4:0] idx, input logic [2:0] ch);
      logic b;
      case (idx)
         5'd0:    b = 1'b1;   // start
         5'd1:    b = 1'b1;   // single-ended
         5'd2:    b = ch[2];
         5'd3:    b = ch[1];
         5'd4:    b = ch[0];
         default: b = 1'b0;   // sample/null slots and data phase
      endcase
      return b;
   endfunction

   logic [1:0]     r_state;
   logic [PCW-1:0] r_period_cnt;
   logic [DCW-1:0] r_div_cnt;
   logic [4:0]     r_bit_cnt;
   logic [GCW-1:0] r_gap_cnt;
   logic [2:0]     r_chan;
   logic [9:0]     r_shift;
   logic           r_miso_s1;
   logic           r_miso_s2;
   logic           r_sclk;
   logic           r_cs_n;
   logic           r_busy;
   logic           r_mosi;
   logic [9:0]     r_sample;
   logic           r_sample_valid;

   logic w_start;
   logic w_half_end;
   logic w_done;

   // A frame may start only from IDLE, which is reached only after the CS gap
   assign w_start    = (r_state == S_IDLE) && (r_period_cnt == PERIOD_LAST) && i_enable;
   assign w_half_end = (r_state == S_XFER) && (r_div_cnt == DIV_LAST);
   // Falling SCLK edge closing the 17th bit ends the transfer
   assign w_done     = w_half_end && r_sclk && (r_bit_cnt == BIT_LAST);

   // Two-flop synchronizer for the asynchronous ADC data line
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_miso_s1 <= 1'b0;
         r_miso_s2 <= 1'b0;
      end else begin
         r_miso_s1 <= i_miso;
         r_miso_s2 <= r_miso_s1;
      end
   end

   // Free-running period counter; holds at its last value, clears only at frame start
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_period_cnt <= '0;
      end else if (w_start) begin
         r_period_cnt <= '0;
      end else if (r_period_cnt != PERIOD_LAST) begin
         r_period_cnt <= r_period_cnt + PCW'(1);
      end else begin
         r_period_cnt <= r_period_cnt;
      end
   end

   // Frame sequencer: chip select, SCLK generation, command shift-out, data shift-in
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state        <= S_IDLE;
         r_div_cnt      <= '0;
         r_bit_cnt      <= 5'd0;
         r_gap_cnt      <= '0;
         r_chan         <= 3'd0;
         r_shift        <= 10'd0;
         r_sclk         <= 1'b0;
         r_cs_n         <= 1'b1;
         r_busy         <= 1'b0;
         r_mosi         <= 1'b0;
         r_sample       <= 10'd0;
         r_sample_valid <= 1'b0;
      end else begin
         r_sample_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_chan    <= i_channel;
                  r_cs_n    <= 1'b0;
                  r_busy    <= 1'b1;
                  r_mosi    <= cmd_bit(5'd0, i_channel);
                  r_sclk    <= 1'b0;
                  r_div_cnt <= '0;
                  r_bit_cnt <= 5'd0;
                  r_state   <= S_XFER;
               end
            end
            S_XFER: begin
               if (!w_half_end) begin
                  r_div_cnt <= r_div_cnt + DCW'(1);
               end else if (!r_sclk) begin
                  // Rising edge: ADC data is valid during the data phase
                  r_div_cnt <= '0;
                  r_sclk    <= 1'b1;
                  if (r_bit_cnt >= DATA_FIRST) begin
                     r_shift <= {r_shift[8:0], r_miso_s2};
                  end
               end else if (w_done) begin
                  // Last falling edge: release the ADC and publish the result
                  r_div_cnt      <= '0;
                  r_sclk         <= 1'b0;
                  r_cs_n         <= 1'b1;
                  r_busy         <= 1'b0;
                  r_mosi         <= 1'b0;
                  r_sample       <= r_shift;
                  r_sample_valid <= 1'b1;
                  r_state        <= S_DONE;
               end else begin
                  // Falling edge: advance to the next bit and present its command value
                  r_div_cnt <= '0;
                  r_sclk    <= 1'b0;
                  r_bit_cnt <= r_bit_cnt + 5'd1;
                  r_mosi    <= cmd_bit(r_bit_cnt + 5'd1, r_chan);
               end
            end
            S_DONE: begin
               r_gap_cnt <= '0;
               r_state   <= S_GAP;
            end
            S_GAP: begin
               if (r_gap_cnt == GAP_LAST) begin
                  r_state <= S_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt + GCW'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_sclk  <= 1'b0;
               r_cs_n  <= 1'b1;
               r_busy  <= 1'b0;
               r_mosi  <= 1'b0;
            end
         endcase
      end
   end

`ifdef ADC_SPI_SAMPLER_ACCEL_MAP_EN
   localparam logic [10:0] LO_11 = 11'(ACCEL_LO);
   localparam logic [10:0] HI_11 = 11'(ACCEL_HI);

   // Throttle map: clamp below LO and at/above HI, else twice the offset from LO
   function automatic logic [9:0] accel_map(input logic [9:0] raw);
      logic [10:0] v;
      v = {1'b0, raw};
      if (v < LO_11) begin
         v = 11'd0;
      end else if (v >= HI_11) begin
         v = 11'd1000;
      end else begin
         v = (v - LO_11) << 1;
      end
      return v[9:0];
   endfunction

   logic [9:0] r_accel;

   // Mapped value updates on the same edge as the published sample
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_accel <= 10'd0;
      end else if (w_done) begin
         r_accel <= accel_map(r_shift);
      end else begin
         r_accel <= r_accel;
      end
   end

   assign o_accel = r_accel;
`else
   assign o_accel = 10'd0;
`endif

   assign o_sclk         = r_sclk;
   assign o_cs_n         = r_cs_n;
   assign o_busy         = r_busy;
   assign o_mosi         = r_mosi;
   assign o_sample       = r_sample;
   assign o_sample_valid = r_sample_valid;

endmodule

// File: doc/adc_spi_sampler.md
Name: adc_spi_sampler

Overview:
- SPI master for an MCP3008-class 10-bit ADC; runs single-ended conversions on a fixed period.
- Sits directly upstream of the motor-control top level and supplies the throttle sample, plus an optional mapped accel value.
- Replaces hand-sequenced CS/DIN counter logic with a self-timed frame state machine and generates its own SCLK.

Parameters:
- CLK_DIV, 675: clk cycles per SCLK half-period. 20 kHz SCLK at 27 MHz. Minimum 1.
- SAMPLE_PERIOD, 86400: clk cycles between frame starts. 3.2 ms at 27 MHz.
- CS_HIGH_CYC, 1350: minimum clk cycles cs_n stays high between frames.
- ACCEL_LO, 280: raw code that maps to accel 0.
- ACCEL_HI, 780: raw code at or above which accel saturates at 1000.

Ports:
- clk  in  1  system clock, 27 MHz.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  allows new frames to start.
- channel  in  3  ADC input select (D2..D0).
- sclk  out  1  SPI clock, mode 0, idles low.
- cs_n  out  1  ADC chip select, active low.
- mosi  out  1  command bits to ADC DIN.
- miso  in  1  ADC DOUT; sampler adds a 2-flop synchronizer.
- sample  out  10  last completed conversion.
- sample_valid  out  1  one-clk pulse when sample updates.
- busy  out  1  high while cs_n is low.
- accel  out  10  mapped throttle, 0..1000 (see Optional Feature).

Behaviour:
- Clock/reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values: cs_n=1, sclk=0, mosi=0, sample=0, sample_valid=0, busy=0, accel=0.
- Reset counter state: period counter=0, FSM=IDLE.
- FSM states: IDLE -> XFER -> DONE -> GAP -> IDLE.
- IDLE:
  - Period counter runs continuously.
  - Frame starts when the counter has reached SAMPLE_PERIOD-1, enable=1, and GAP is complete.
  - On start: latch channel, period counter -> 0, cs_n -> 0, mosi = first command bit, go to XFER.
- XFER: 17 SCLK cycles, each 2*CLK_DIV clk cycles (low half, then high half).
  - Bits 1-5: mosi = 1 (start), 1 (SGL), D2, D1, D0 of the latched channel.
  - Bits 6-7: sample and null bits; mosi=0.
  - Bits 8-17: data B9..B0, MSB first.
  - mosi changes only on the clk edge where sclk falls, or at frame start.
  - The synchronized miso is shifted in on the clk edge where sclk rises, during bits 8-17 only.
  - The synchronizer delay is 2 clk cycles and is accepted; requires CLK_DIV>=3 in silicon. Benches may use CLK_DIV=3.
- DONE: one clk cycle after the 17th falling edge.
  - cs_n -> 1, busy -> 0.
  - sample <= shift register; sample_valid=1 for exactly this cycle.
  - Go to GAP.
- GAP: hold cs_n=1 for CS_HIGH_CYC clk cycles, then go to IDLE.
- If SAMPLE_PERIOD is less than frame length plus CS_HIGH_CYC, the next frame starts immediately after GAP (back-to-back). No error is raised.
- enable dropped mid-frame: the current frame completes and updates sample. No new frame starts.
- channel change mid-frame: ignored until the next frame start.
- rst_n asserted mid-frame: all outputs go to reset values asynchronously. The partial result is discarded and sample_valid does not pulse.
- busy is exactly ~cs_n.
- Period counter width is $clog2(SAMPLE_PERIOD); it wraps to 0 at frame start only.

Optional Feature:
- Macro: ADC_SPI_SAMPLER_ACCEL_MAP_EN.
- Defined: accel updates in the same cycle as sample.
  - accel = 0 if sample < ACCEL_LO.
  - accel = 1000 if sample >= ACCEL_HI.
  - Otherwise accel = (sample - ACCEL_LO) * 2.
  - Intermediate math is 11 bits unsigned; result is truncated to 10 bits after clamping.
- Not defined: accel is tied to constant 0 and no mapping logic is synthesized.

Test Plan:
- Reset release, enable=1, CLK_DIV=3, SAMPLE_PERIOD=200, CS_HIGH_CYC=4, channel=4 -> first frame starts at clk 199; mosi bits 1,1,1,0,0; exactly 17 sclk rising edges; frame lasts 102 clk cycles.
- ADC model returns 0x2A5 -> sample=677 with a single sample_valid pulse at cs_n rise; accel=794 with the macro, 0 without.
- ADC model returns 100 then 1023 -> accel=0, then accel=1000.
- Change channel from 4 to 1 at bit 3 of a frame -> current frame sends D2..D0=1,0,0; next frame sends 0,0,1.
- Deassert enable at SCLK bit 10 -> frame completes, sample_valid pulses once, cs_n stays high thereafter.
- Assert rst_n=0 at SCLK bit 12 -> cs_n=1 and sclk=0 in the same cycle, sample=0, no sample_valid; the first frame after release is complete and correct.
